// File: rtl/irrigation_actuator_sequencer_if.sv
// irrigation_actuator_sequencer_if: request/status bundle between the activation source and the valve/pump sequencer.
interface irrigation_actuator_sequencer_if;
    logic irrigation_state_i;
    logic fault_clr_i;
    logic valve_o;
    logic pump_o;
    logic busy_o;
    logic done_o;
    logic fault_o;
    modport master (
        output irrigation_state_i, fault_clr_i,
        input  valve_o, pump_o, busy_o, done_o, fault_o
    );
    modport slave (
        input  irrigation_state_i, fault_clr_i,
        output valve_o, pump_o, busy_o, done_o, fault_o
    );
endinterface

// File: rtl/irrigation_actuator_sequencer.sv
// irrigation_actuator_sequencer: debounced request drives a timed open/settle/run/close/rest valve-pump sequence with run timeout fault.
module irrigation_actuator_sequencer #(
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 8,
    parameter int SETTLE   = 100,
    parameter int MIN_ON   = 500,
    parameter int MAX_ON   = 5000,
    parameter int LOCKOUT  = 1000
) (
    input logic clk_i,
    input logic rst_n_i,
    irrigation_actuator_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_OPEN, S_RUN, S_CLOSE, S_REST, S_FAULT} state_t;
    localparam logic [CNT_W-1:0] DB_T   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] SET_T  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] MIN_T  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] MAX_T  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] LOCK_T = CNT_W'(LOCKOUT - 1);
    state_t state, nxt;
    logic sync1, sync2, req_db;
    logic [CNT_W-1:0] db_cnt, cnt;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            req_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= bus.irrigation_state_i;
            sync2 <= sync1;
            if (sync2 != req_db) begin
                req_db <= (db_cnt == DB_T) ? sync2 : req_db;
                db_cnt <= (db_cnt == DB_T) ? '0 : db_cnt + CNT_W'(1);
            end else begin
                db_cnt <= '0;
            end
        end
    end
    // A drop before MIN_ON is held off; the timeout only fires while the request persists.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = req_db ? S_OPEN : S_IDLE;
            S_OPEN:  nxt = !req_db ? S_CLOSE : (cnt == SET_T ? S_RUN : S_OPEN);
            S_RUN:   nxt = (!req_db && cnt >= MIN_T) ? S_CLOSE : (cnt >= MAX_T ? S_FAULT : S_RUN);
            S_CLOSE: nxt = (cnt == SET_T) ? S_REST : S_CLOSE;
            S_REST:  nxt = (cnt == LOCK_T) ? S_IDLE : S_REST;
            S_FAULT: nxt = bus.fault_clr_i ? S_IDLE : S_FAULT;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bus.valve_o <= 1'b0;
            bus.pump_o  <= 1'b0;
            bus.busy_o  <= 1'b0;
            bus.done_o  <= 1'b0;
            bus.fault_o <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= (nxt != state) ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
            bus.valve_o <= nxt inside {S_OPEN, S_RUN, S_CLOSE};
            bus.pump_o  <= nxt == S_RUN;
            bus.busy_o  <= nxt != S_IDLE;
            bus.done_o  <= state == S_CLOSE && nxt == S_REST;
            bus.fault_o <= nxt == S_FAULT;
        end
    end
endmodule
